// File: rtl/tea_pkg.sv
// tea_pkg: shared state encoding and frame layout constants for the TEA frame loader
package tea_pkg;
  typedef enum logic [2:0] {HDR, KEY, DATA, FIRE, WAIT, OUT} state_t;
  localparam int HDR_ED_BIT   = 0;
  localparam int HDR_KEEP_BIT = 1;
  localparam int KEY_BYTES    = 4;
  localparam int DATA_BYTES   = 2;
endpackage

// File: rtl/tea_pulse_timer.sv
// tea_pulse_timer: loadable down-counter that times the FIRE and WAIT phases
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : load i_value (takes priority over counting)
//   i_value    : value to load
//   i_en       : count down while nonzero
//   o_done     : counter is zero
module tea_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_en && !o_done) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/tea_frame_loader.sv
// tea_frame_loader: byte-stream framer that loads the TEA ALU, pulses readyBit and returns its results
//   in_valid/in_ready/in_data    : header, optional 4 key bytes, 2 data bytes
//   e_d, key0..3, v0, v1         : held ALU operands
//   ready_bit                    : registered ALU start pulse, PULSE_CYCLES wide
//   alu_result0/1                : ALU results, sampled SETTLE_CYCLES after ready_bit falls
//   out_valid/out_ready/out_data : captured result pair
//   busy, err                    : not in HDR / one-cycle rejected-header pulse
module tea_frame_loader
  import tea_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       e_d,
  output logic [7:0] key0,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [7:0] key3,
  output logic [7:0] v0,
  output logic [7:0] v1,
  output logic       ready_bit,
  input  logic [7:0] alu_result0,
  input  logic [7:0] alu_result1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data0,
  output logic [7:0] out_data1,
  output logic       busy,
  output logic       err
);
  state_t     r_state;
  logic [1:0] r_idx;
  logic       r_key_loaded, r_in_ready, r_e_d, r_ready_bit, r_out_valid, r_err;
  logic [7:0] r_key0, r_key1, r_key2, r_key3, r_v0, r_v1, r_out0, r_out1;
  logic       w_xfer, w_last_data, w_load, w_done;
  logic [CNT_W-1:0] w_value;
  assign w_xfer      = in_valid && r_in_ready;
  assign w_last_data = r_state == DATA && w_xfer && r_idx == 2'(DATA_BYTES - 1);
  assign w_load      = w_last_data || (r_state == FIRE && w_done);
  assign w_value     = r_state == FIRE ? CNT_W'(SETTLE_CYCLES - 1) : CNT_W'(PULSE_CYCLES - 1);
  tea_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_value(w_value),
    .i_en   (r_state == FIRE || r_state == WAIT),
    .o_done (w_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HDR;
      r_idx        <= '0;
      r_key_loaded <= 1'b0;
      r_in_ready   <= 1'b0;
      r_e_d        <= 1'b0;
      r_ready_bit  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_key0       <= '0;
      r_key1       <= '0;
      r_key2       <= '0;
      r_key3       <= '0;
      r_v0         <= '0;
      r_v1         <= '0;
      r_out0       <= '0;
      r_out1       <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        HDR: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_idx <= '0;
            if (!in_data[HDR_KEEP_BIT] || r_key_loaded) begin
              r_e_d   <= in_data[HDR_ED_BIT];
              r_state <= in_data[HDR_KEEP_BIT] ? DATA : KEY;
            end else r_err <= 1'b1;
          end
        end
        KEY: if (w_xfer) begin
          if (r_idx == 2'd0) r_key0 <= in_data;
          if (r_idx == 2'd1) r_key1 <= in_data;
          if (r_idx == 2'd2) r_key2 <= in_data;
          if (r_idx == 2'd3) r_key3 <= in_data;
          r_idx <= r_idx + 1'b1;
          if (r_idx == 2'(KEY_BYTES - 1)) begin
            r_key_loaded <= 1'b1;
            r_state      <= DATA;
          end
        end
        DATA: if (w_xfer) begin
          if (w_last_data) begin
            r_v1        <= in_data;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_ready_bit <= 1'b1;
            r_state     <= FIRE;
          end else begin
            r_v0  <= in_data;
            r_idx <= r_idx + 1'b1;
          end
        end
        FIRE: if (w_done) begin
          r_ready_bit <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (w_done) begin
          r_out0      <= alu_result0;
          r_out1      <= alu_result1;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= HDR;
        end
        default: r_state <= HDR;
      endcase
    end
  end
  assign in_ready  = r_in_ready;
  assign e_d       = r_e_d;
  assign key0      = r_key0;
  assign key1      = r_key1;
  assign key2      = r_key2;
  assign key3      = r_key3;
  assign v0        = r_v0;
  assign v1        = r_v1;
  assign ready_bit = r_ready_bit;
  assign out_valid = r_out_valid;
  assign out_data0 = r_out0;
  assign out_data1 = r_out1;
  assign busy      = r_state != HDR;
  assign err       = r_err;
endmodule
